shift_muldiv_ctrl: RTL and testbench

SHIFT_MULDIV_CTRL -- requirements
Module: shift_muldiv_ctrl

---
 rtl/shift_muldiv_ctrl_if.sv | 27 ++
 rtl/shift_muldiv_ctrl.sv | 128 ++++++++++++
 tb/tb_shift_muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_muldiv_ctrl_if.sv
// Request/response bundle for the iterative shift multiplier/divider.
// The requester uses the master modport, the datapath block uses the slave modport.
interface shift_muldiv_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 div0;
    logic                 op_out;
    logic                 busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, div0, op_out, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, div0, op_out, busy
    );
endinterface

// File: rtl/shift_muldiv_ctrl.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Fixed latency of WIDTH+1 edges from accept to out_valid for every operation.
module shift_muldiv_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e               state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic                 op_q,     op_d;
    logic [WIDTH-1:0]     dvsr_q,   dvsr_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div0_q,   div0_d;
    logic                 op_out_q, op_out_d;

    // Divide: acc holds {partial remainder, unconsumed dividend bits / quotient bits}.
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     diff;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dvsr_d   = dvsr_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        div0_d   = div0_q;
        op_out_d = op_out_q;
        trial    = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = trial[WIDTH-1:0] - dvsr_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    op_d     = bus.op;
                    dvsr_d   = bus.b;
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = bus.op ? {{WIDTH{1'b0}}, bus.a} : '0;
                end
            end
            CALC: begin
                // Counts 0..WIDTH-1 doing iterations; the extra count commits the result.
                if (cnt_q == CW'(WIDTH)) begin
                    state_d  = DONE;
                    result_d = acc_q;
                    div0_d   = op_q & (dvsr_q == '0);
                    op_out_d = op_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q) begin
                        if (trial >= {1'b0, dvsr_q}) begin
                            acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            dvsr_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
            op_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dvsr_q   <= dvsr_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            div0_q   <= div0_d;
            op_out_q <= op_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.div0      = div0_q;
    assign bus.op_out    = op_out_q;
endmodule

// File: tb/tb_shift_muldiv_ctrl.sv
// Self-checking bench for shift_muldiv_ctrl: a latency/arithmetic reference model
// compared every cycle, plus directed operations with hand-computed results.
module tb_shift_muldiv_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    shift_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_result(input logic op_v, input logic [W-1:0] a_v,
                                                   input logic [W-1:0] b_v);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (!op_v) return (2*W)'(a_v) * (2*W)'(b_v);
        if (b_v == '0) return {a_v, {W{1'b1}}};
        q = a_v / b_v;
        r = a_v % b_v;
        return {r, q};
    endfunction

    // Reference model: phase 0 idle, 1 computing (countdown), 2 result offered.
    int              m_phase = 0;
    int              m_left  = 0;
    logic [2*W-1:0]  m_pending;
    logic            m_pend_div0;
    logic            m_pend_op;
    logic [2*W-1:0]  m_result;
    logic            m_div0;
    logic            m_op;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_result = '0;
            m_div0   = 1'b0;
            m_op     = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_phase     = 1;
                    m_left      = W + 1;
                    m_pending   = ref_result(bus.op, bus.a, bus.b);
                    m_pend_div0 = bus.op && (bus.b == '0);
                    m_pend_op   = bus.op;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase  = 2;
                        m_result = m_pending;
                        m_div0   = m_pend_div0;
                        m_op     = m_pend_op;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("cmp_in_ready",  bus.in_ready,  m_phase == 0);
            check("cmp_out_valid", bus.out_valid, m_phase == 2);
            check("cmp_busy",      bus.busy,      m_phase != 0);
            check("cmp_result",    bus.result,    m_result);
            check("cmp_div0",      bus.div0,      m_div0);
            check("cmp_op_out",    bus.op_out,    m_op);
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input int hold, output logic [2*W-1:0] res, output logic d0,
                         output logic opo);
        int guard = 0;
        int lat;
        while (m_phase != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("idle_timeout", guard, 0);
        bus.op = op_v; bus.a = a_v; bus.b = b_v; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("latency", lat, W + 1);
        res = bus.result; d0 = bus.div0; opo = bus.op_out;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] res;
        logic           d0;
        logic           opo;
        int             lat;
        int             seen;

        bus.in_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_result",    bus.result,    0);

        do_op(1'b0, 4'd15, 4'd15, 0, res, d0, opo);
        check("mul_15x15", res, 8'hE1);
        check("mul_div0", d0, 0);
        check("mul_op_out", opo, 0);

        do_op(1'b1, 4'd13, 4'd4, 0, res, d0, opo);
        check("div_13_4", res, 8'h13);
        check("div_div0", d0, 0);
        check("div_op_out", opo, 1);

        do_op(1'b1, 4'd9, 4'd0, 0, res, d0, opo);
        check("div_by_zero", res, 8'h9F);
        check("div0_flag", d0, 1);

        // Backpressure: result held 3 cycles in DONE, then IDLE right after release.
        do_op(1'b0, 4'd6, 4'd7, 3, res, d0, opo);
        check("bp_result", res, 8'h2A);
        check("bp_idle_after", bus.in_ready, 1);

        // Operand changes and in_valid pulses while busy must not disturb the result.
        bus.op = 1'b0; bus.a = 4'd7; bus.b = 4'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.op = 1'b1; bus.a = 4'd0; bus.b = 4'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("busy_latency", lat + 3, W + 1);
        check("busy_result", bus.result, 8'h3F);
        check("busy_op_out", bus.op_out, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // in_valid held through DONE: no accept until the following IDLE cycle.
        bus.op = 1'b0; bus.a = 4'd3; bus.b = 4'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("mul_3x5", bus.result, 8'h0F);
        bus.op = 1'b1; bus.a = 4'd13; bus.b = 4'd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("done_hold_valid", bus.out_valid, 1);
        check("done_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("no_accept_in_done", bus.busy, 0);
        @(posedge clk); #1;
        check("accept_after_done", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("late_accept_latency", lat, W + 1);
        check("late_accept_result", bus.result, 8'h13);

        // Reset wins over DONE with out_ready=1.
        bus.out_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.out_ready = 1'b0;
        check("rst_done_result", bus.result, 0);
        check("rst_done_in_ready", bus.in_ready, 1);
        check("rst_done_op_out", bus.op_out, 0);

        // Reset during the second CALC cycle discards the operation.
        bus.op = 1'b0; bus.a = 4'd15; bus.b = 4'd15; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_result", bus.result, 0);
        check("abort_div0", bus.div0, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            seen += int'(bus.out_valid);
        end
        check("abort_no_valid", seen, 0);

        // Every {op,a,b}: the per-cycle compare checks results against the model.
        for (int o = 0; o < 2; o++) begin
            for (int ai = 0; ai < (1 << W); ai++) begin
                for (int bi = 0; bi < (1 << W); bi++) begin
                    do_op(o[0], W'(ai), W'(bi), 0, res, d0, opo);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
